// File: rtl/pic_pkg.sv
// pic_defs: shared register offsets, decode mask, read fill values and byte-lane helper for pic
package pic_defs;
    localparam logic [4:0] PIC_STATUS_OFFSET = 5'd0;
    localparam logic [4:0] PIC_ENABLE_OFFSET = 5'd4;
    localparam logic [4:0] PIC_MODE_OFFSET   = 5'd8;
    localparam logic [4:0] PIC_CLEAR_OFFSET  = 5'd12;
    localparam logic [4:0] PIC_ID_OFFSET     = 5'd16;
    localparam logic [4:0] PIC_UA_OFFSET     = 5'd20;
    localparam logic [4:0] ADDR_CHECK        = 5'b11100;
    localparam logic [31:0] DEAD_F00D        = 32'hDEAD_F00D;
    localparam logic [31:0] DEAD_B00B        = 32'hDEAD_B00B;

    function automatic logic [31:0] lane_mask(input logic [3:0] wr);
        return {{8{wr[3]}}, {8{wr[2]}}, {8{wr[1]}}, {8{wr[0]}}};
    endfunction
endpackage

// File: rtl/pic_priority_enc.sv
// pic_priority_enc: lowest-index-first priority encoder
//   pend_i  : pending vector, bit 0 highest priority
//   valid_o : any bit pending
//   id_o    : index of lowest set bit, 0 when none
module pic_priority_enc #(
    parameter int N_SRC = 8
) (
    input  logic [N_SRC-1:0] pend_i,
    output logic             valid_o,
    output logic [4:0]       id_o
);
    assign valid_o = |pend_i;

    // Scanning downward lets the lowest set index overwrite any higher one.
    always_comb begin
        id_o = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (pend_i[i]) id_o = 5'(i);
    end
endmodule

// File: rtl/pic.sv
// pic: bus-mapped interrupt controller latching, masking and prioritising N_SRC sources
//   clk, rst             : clock, async active-high reset
//   pic_src              : interrupt source lines
//   pic_address/data_i/wr/enable : slave bus request; pic_wr==0 means read
//   pic_data_o, pic_ready: read data and registered acknowledge
//   pic_irq, pic_irq_id  : registered request and highest-priority source index
module pic
    import pic_defs::*;
#(
    parameter int N_SRC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] pic_src,
    input  logic [4:0]       pic_address,
    input  logic [31:0]      pic_data_i,
    input  logic [3:0]       pic_wr,
    input  logic             pic_enable,
    output logic [31:0]      pic_data_o,
    output logic             pic_ready,
    output logic             pic_irq,
    output logic [4:0]       pic_irq_id
);
    logic [N_SRC-1:0] status_q, status_d, enable_q, enable_d, mode_q, mode_d, src_prev_q, clr, pend;
    logic [31:0]      wmask, enable_w, mode_w, clr_w;
    logic [4:0]       offset, enc_id, irq_id_q;
    logic             implemented, wr_en, rd_active, enc_valid, ready_q, irq_q;

    assign offset      = pic_address & ADDR_CHECK;
    assign implemented = pic_address < PIC_UA_OFFSET;
    assign wr_en       = pic_enable & implemented & (|pic_wr);
    assign wmask       = lane_mask(pic_wr);
    assign enable_w    = (32'(enable_q) & ~wmask) | (pic_data_i & wmask);
    assign mode_w      = (32'(mode_q) & ~wmask) | (pic_data_i & wmask);
    assign clr_w       = pic_data_i & wmask;
    assign enable_d    = (wr_en && offset == PIC_ENABLE_OFFSET) ? enable_w[N_SRC-1:0] : enable_q;
    assign mode_d      = (wr_en && offset == PIC_MODE_OFFSET) ? mode_w[N_SRC-1:0] : mode_q;
    assign clr         = (wr_en && offset == PIC_CLEAR_OFFSET) ? clr_w[N_SRC-1:0] : '0;
    // Edge bits: a new edge beats a same-cycle clear. Level bits follow the line.
    // Any bit whose mode flips starts clean so the old mode's state cannot leak.
    assign status_d    = (((pic_src & ~src_prev_q) | (status_q & ~clr)) & mode_q
                         | (pic_src & ~mode_q)) & ~(mode_q ^ mode_d);
    assign pend        = status_q & enable_q;

    pic_priority_enc #(.N_SRC(N_SRC)) u_enc (
        .pend_i  (pend),
        .valid_o (enc_valid),
        .id_o    (enc_id)
    );

    // Reads stay valid during the ack cycle so the bus can sample with ready.
    assign rd_active = (pic_enable | ready_q) & (pic_wr == 4'b0000);

    always_comb begin
        pic_data_o = !rd_active                   ? DEAD_B00B :
                     !implemented                 ? DEAD_F00D :
                     offset == PIC_STATUS_OFFSET  ? 32'(status_q) :
                     offset == PIC_ENABLE_OFFSET  ? 32'(enable_q) :
                     offset == PIC_MODE_OFFSET    ? 32'(mode_q) :
                     offset == PIC_ID_OFFSET      ? {irq_q, 26'd0, irq_id_q} : 32'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q   <= '0;
            enable_q   <= '0;
            mode_q     <= '0;
            src_prev_q <= '0;
            ready_q    <= 1'b0;
            irq_q      <= 1'b0;
            irq_id_q   <= '0;
        end else begin
            status_q   <= status_d;
            enable_q   <= enable_d;
            mode_q     <= mode_d;
            src_prev_q <= pic_src;
            ready_q    <= pic_enable & implemented;
            irq_q      <= enc_valid;
            irq_id_q   <= enc_id;
        end
    end

    assign pic_ready  = ready_q;
    assign pic_irq    = irq_q;
    assign pic_irq_id = irq_id_q;
endmodule

// File: tb/tb_pic.sv
// tb_pic: directed and randomized checks of pic against a per-register behavioural model
module tb_pic;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] pic_src;
    logic [4:0]   pic_address;
    logic [31:0]  pic_data_i;
    logic [3:0]   pic_wr;
    logic         pic_enable;
    logic [31:0]  pic_data_o;
    logic         pic_ready;
    logic         pic_irq;
    logic [4:0]   pic_irq_id;

    int tests = 0;
    int fails = 0;

    logic [N-1:0] m_status, m_enable, m_mode, m_prev;
    logic         m_ready, m_irq;
    logic [4:0]   m_id;

    pic #(.N_SRC(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .pic_src     (pic_src),
        .pic_address (pic_address),
        .pic_data_i  (pic_data_i),
        .pic_wr      (pic_wr),
        .pic_enable  (pic_enable),
        .pic_data_o  (pic_data_o),
        .pic_ready   (pic_ready),
        .pic_irq     (pic_irq),
        .pic_irq_id  (pic_irq_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_status = '0; m_enable = '0; m_mode = '0; m_prev = '0;
        m_ready = 1'b0; m_irq = 1'b0; m_id = '0;
    endtask

    function automatic logic [31:0] model_rd();
        if (!((pic_enable || m_ready) && pic_wr == 4'b0000)) return 32'hDEAD_B00B;
        if (pic_address >= 5'd20) return 32'hDEAD_F00D;
        case (pic_address[4:2])
            3'd0:    return {24'd0, m_status};
            3'd1:    return {24'd0, m_enable};
            3'd2:    return {24'd0, m_mode};
            3'd4:    return {m_irq, 26'd0, m_id};
            default: return 32'd0;
        endcase
    endfunction

    // One clock: check the read path before the edge, advance the model, check registered outputs after.
    task automatic step();
        logic [31:0] wm, nv;
        logic [N-1:0] n_en, n_mode, clr, n_st, pend, src;
        logic n_irq, n_ready, found;
        logic [4:0] n_id;
        #1;
        chk("data_o", pic_data_o, model_rd());
        wm = {{8{pic_wr[3]}}, {8{pic_wr[2]}}, {8{pic_wr[1]}}, {8{pic_wr[0]}}};
        n_en = m_enable; n_mode = m_mode; clr = '0; src = pic_src;
        n_ready = pic_enable && pic_address < 5'd20;
        if (n_ready && pic_wr != 4'b0000) begin
            case (pic_address[4:2])
                3'd1: begin nv = ({24'd0, m_enable} & ~wm) | (pic_data_i & wm); n_en = nv[N-1:0]; end
                3'd2: begin nv = ({24'd0, m_mode} & ~wm) | (pic_data_i & wm); n_mode = nv[N-1:0]; end
                3'd3: begin nv = pic_data_i & wm; clr = nv[N-1:0]; end
                default: ;
            endcase
        end
        pend = m_status & m_enable;
        n_irq = pend != '0; n_id = '0; found = 1'b0;
        for (int i = 0; i < N; i++)
            if (pend[i] && !found) begin n_id = 5'(i); found = 1'b1; end
        for (int i = 0; i < N; i++) begin
            if (n_mode[i] != m_mode[i]) n_st[i] = 1'b0;
            else if (m_mode[i]) n_st[i] = (src[i] && !m_prev[i]) || (m_status[i] && !clr[i]);
            else n_st[i] = src[i];
        end
        @(posedge clk);
        m_status = n_st; m_enable = n_en; m_mode = n_mode; m_prev = src;
        m_ready = n_ready; m_irq = n_irq; m_id = n_id;
        #1;
        chk("ready", {31'd0, pic_ready}, {31'd0, m_ready});
        chk("irq", {31'd0, pic_irq}, {31'd0, m_irq});
        chk("irq_id", {27'd0, pic_irq_id}, {27'd0, m_id});
    endtask

    task automatic bus(input logic [4:0] a, input logic [31:0] d, input logic [3:0] w);
        pic_enable = 1'b1; pic_address = a; pic_data_i = d; pic_wr = w;
        step();
        pic_enable = 1'b0; pic_wr = 4'b0000;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
        pic_enable = 1'b1; pic_address = a; pic_wr = 4'b0000;
        #1;
        chk(tag, pic_data_o, exp);
        step();
        pic_enable = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pic_src = '0; pic_address = '0; pic_data_i = '0; pic_wr = '0; pic_enable = 1'b0;
        model_reset();
        #12 rst = 1'b0;

        // reset state
        chk("rst_ready", {31'd0, pic_ready}, 32'd0);
        rd(5'h00, 32'd0, "rst_status");
        chk("rd_ready", {31'd0, pic_ready}, 32'd1);
        rd(5'h04, 32'd0, "rst_enable");
        rd(5'h08, 32'd0, "rst_mode");
        rd(5'h10, 32'd0, "rst_id");
        chk("rst_irq", {31'd0, pic_irq}, 32'd0);

        // level mode
        bus(5'h04, 32'h0000_000F, 4'b0001);
        pic_src = 8'h04;
        step(); chk("lvl_irq_1", {31'd0, pic_irq}, 32'd0);
        step(); chk("lvl_irq_2", {31'd0, pic_irq}, 32'd1); chk("lvl_id", {27'd0, pic_irq_id}, 32'd2);
        pic_src = 8'h00;
        step(); chk("lvl_drop_1", {31'd0, pic_irq}, 32'd1);
        step(); chk("lvl_drop_2", {31'd0, pic_irq}, 32'd0);

        // edge mode
        bus(5'h08, 32'h0000_0080, 4'b0001);
        bus(5'h04, 32'h0000_0080, 4'b0001);
        pic_src = 8'h80; step();
        pic_src = 8'h00; step();
        rd(5'h00, 32'h0000_0080, "edge_status");
        step(); step();
        rd(5'h00, 32'h0000_0080, "edge_sticky");
        rd(5'h10, 32'h8000_0007, "edge_id");
        bus(5'h0C, 32'h0000_0080, 4'b0001);
        chk("clr_irq_hold", {31'd0, pic_irq}, 32'd1);
        step(); chk("clr_irq_drop", {31'd0, pic_irq}, 32'd0);
        rd(5'h00, 32'd0, "clr_status");

        // set beats clear in the same cycle
        pic_src = 8'h80; step();
        pic_src = 8'h00; step();
        pic_src = 8'h80; bus(5'h0C, 32'h0000_0080, 4'b0001);
        pic_src = 8'h00;
        rd(5'h00, 32'h0000_0080, "set_wins");

        // priority between sources 1 and 5
        bus(5'h04, 32'h0000_0022, 4'b0001);
        bus(5'h08, 32'h0000_00A2, 4'b0001);
        pic_src = 8'h22; step();
        pic_src = 8'h00; step(); step();
        chk("prio_id_1", {27'd0, pic_irq_id}, 32'd1);
        bus(5'h0C, 32'h0000_0002, 4'b0001);
        step(); chk("prio_id_5", {27'd0, pic_irq_id}, 32'd5);

        // unimplemented address, idle bus, byte lanes
        rd(5'h14, 32'hDEAD_F00D, "ua_data");
        chk("ua_ready", {31'd0, pic_ready}, 32'd0);
        #1 chk("idle_data", pic_data_o, 32'hDEAD_B00B);
        bus(5'h04, 32'h0000_0000, 4'b1111);
        bus(5'h04, 32'hFFFF_FFFF, 4'b0010);
        rd(5'h04, 32'd0, "lane_enable");

        // async reset mid-operation
        bus(5'h08, 32'h0000_0000, 4'b1111);
        bus(5'h04, 32'h0000_00FF, 4'b0001);
        pic_src = 8'h10; step(); step(); step();
        chk("pre_rst_irq", {31'd0, pic_irq}, 32'd1);
        pic_enable = 1'b1; pic_address = 5'h00; step();
        #2 rst = 1'b1; pic_enable = 1'b0;
        #1;
        chk("arst_irq", {31'd0, pic_irq}, 32'd0);
        chk("arst_id", {27'd0, pic_irq_id}, 32'd0);
        chk("arst_ready", {31'd0, pic_ready}, 32'd0);
        model_reset();
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 1'b0;
        step(); step(); step(); step();
        chk("post_rst_irq", {31'd0, pic_irq}, 32'd0);
        rd(5'h04, 32'd0, "post_rst_enable");
        rd(5'h08, 32'd0, "post_rst_mode");
        bus(5'h04, 32'h0000_0010, 4'b0001);
        step(); step();
        chk("re_en_irq", {31'd0, pic_irq}, 32'd1);
        chk("re_en_id", {27'd0, pic_irq_id}, 32'd4);

        // randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            pic_src = N'($urandom);
            if ($urandom_range(0, 9) < 4) begin
                pic_enable = 1'b1;
                pic_address = 5'($urandom_range(0, 31));
                pic_wr = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 2) == 0) pic_wr = 4'b0000;
                pic_data_i = $urandom;
            end else begin
                pic_enable = 1'b0; pic_wr = 4'b0000;
            end
            step();
        end
        pic_enable = 1'b0; pic_wr = 4'b0000;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
